demultiplexer_1x2_32b: RTL
==========================

Name: demultiplexer_1x2_32b

Overview:
- Registered 1-to-2 demultiplexer: the write-side counterpart of the 2x1 32-bit multiplexer.
- Accepts one 32-bit word stream and routes each word to one of two destinations, selected by the control unit's IR_CU line.
- Each destination is buffered by its own small FIFO, so one stalled consumer does not lose data.
- Sits between the datapath result bus and two consumers, e.g. the register-file write port and the memory write buffer.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, >= 2.
- PTR_W, 1, log2(DEPTH); must be set consistently with DEPTH.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- IN  input  WIDTH  incoming data word.
- IN_VALID  input  1  IN holds a word to transfer.
- IN_READY  output  1  block can accept a word for the destination currently selected by IR_CU.
- IR_CU  input  1  destination select from the control unit: 0 routes to OUT1, 1 routes to OUT2.
- OUT1  output  WIDTH  head word of FIFO 1.
- OUT1_VALID  output  1  FIFO 1 not empty.
- OUT1_READY  input  1  consumer 1 takes the head word.
- OUT2  output  WIDTH  head word of FIFO 2.
- OUT2_VALID  output  1  FIFO 2 not empty.
- OUT2_READY  input  1  consumer 2 takes the head word.

Behaviour:
- Reset (async, active-high):
  - Both FIFOs cleared; read/write pointers and counts = 0.
  - OUT1_VALID = OUT2_VALID = 0; OUT1 = OUT2 = 0.
  - IN_READY = 1 once RESET deasserts.
  - Reset mid-transfer discards all buffered words; no partial word survives.
- IN_READY is combinational and depends only on IR_CU and the target FIFO's full flag: IN_READY = IR_CU ? !full2 : !full1.
- IN_READY never depends on OUTn_READY, so there is no combinational path from output ready to input ready.
- Accept: IN_VALID && IN_READY at a rising CLK edge. IN is written into the FIFO selected by IR_CU as sampled at that edge.
- IR_CU may change every cycle; each word is routed by its own acceptance-cycle IR_CU.
- Latency: a word accepted at edge t is visible on OUTn with OUTn_VALID = 1 after edge t (one cycle), if its FIFO was empty.
- OUTn is driven from FIFO storage at the read pointer and gated to 0 when the FIFO is empty.
- Pop: OUTn_VALID && OUTn_READY at an edge advances read pointer n. OUTn_READY while empty is ignored.
- Ordering: each output preserves acceptance order of the words routed to it. There is no ordering guarantee between OUT1 and OUT2.
- Simultaneous push and pop on the same FIFO in the same cycle (FIFO not full): count unchanged, both pointers advance.
- Full FIFO: no push is possible because IN_READY = 0. A pop in that cycle frees a slot from the next cycle.
- Empty FIFO with push and no pop: count goes 0 -> 1 and OUTn_VALID rises next cycle. There is no bypass, so latency is always at least 1.
- Pointers are PTR_W bits wide and wrap modulo DEPTH. Count is PTR_W+1 bits: full = (count == DEPTH), empty = (count == 0).
- A push to one FIFO and a pop from the other in the same cycle are fully independent.
- If IN_VALID = 0, IN and IR_CU are don't-care and no state changes on the input side.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - Adds output ports COUNT1 and COUNT2, 16 bits each.
  - Each counts words accepted into its FIFO since reset.
  - Counters wrap 16'hFFFF -> 0 and reset to 0 asynchronously.
  - Each increments on the same edge as the corresponding accept.
- Not defined: ports and counters are absent. Routing behaviour is identical in both builds.

Test Plan:
1. Reset: assert RESET mid-cycle with FIFOs holding data -> OUT1_VALID = OUT2_VALID = 0 and OUT1 = OUT2 = 0 immediately; IN_READY = 1 after deassert.
2. Basic routing: IN=1, IR_CU=0, IN_VALID=1 for one cycle, then IN=2, IR_CU=1 -> OUT1=1 with OUT1_VALID one cycle after the first accept; OUT2=2 with OUT2_VALID one cycle after the second.
3. Full/backpressure: OUT1_READY=0; push 32'hA, 32'hB to IR_CU=0 -> IN_READY=0 while IR_CU=0 and IN_READY=1 when IR_CU switches to 1. Raise OUT1_READY -> OUT1 shows A, then B, in order.
4. Simultaneous push/pop: FIFO 2 holds 1 word; push 32'h5 with IR_CU=1 while OUT2_READY=1 -> count stays 1 and OUT2 = 32'h5 next cycle.
5. Wrap-around: stream 8 words 0..7 to OUT1 with OUT1_READY=1 every cycle -> OUT1 sequence 0..7 with no gaps or duplicates; pointers wrap 4 times at DEPTH=2.
6. DEMUX_COUNT_EN build: route 3 words to OUT1 and 2 to OUT2 -> COUNT1=3 and COUNT2=2. Preload COUNT1 to 16'hFFFF, then one more accept -> COUNT1 = 0.

Source files
------------

// File: rtl/demultiplexer_1x2_32b.sv
// Registered 1-to-2 demultiplexer: each word is routed by IR_CU into one of two small FIFOs.
// Optional macro DEMUX_COUNT_EN adds per-destination 16-bit accept counters COUNT1/COUNT2.
module demultiplexer_1x2_32b #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IR_CU,
    output logic [WIDTH-1:0] OUT1,
    output logic             OUT1_VALID,
    input  logic             OUT1_READY,
    output logic [WIDTH-1:0] OUT2,
    output logic             OUT2_VALID,
    input  logic             OUT2_READY
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      COUNT1,
    output logic [15:0]      COUNT2
`endif
);

    logic [1:0] full;
    logic [1:0] out_ready;

    assign out_ready = {OUT2_READY, OUT1_READY};

    // Ready looks only at the selected FIFO's full flag, never at the output ready lines.
    assign IN_READY = IR_CU ? !full[1] : !full[0];

    for (genvar gi = 0; gi < 2; gi++) begin : fifo_g
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [PTR_W:0]   count_q, count_d;
        logic             empty;
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] head;

        assign full[gi] = (count_q == (PTR_W+1)'(DEPTH));
        assign empty    = (count_q == '0);
        assign push     = IN_VALID && !full[gi] && (IR_CU == (gi == 1));
        assign pop      = !empty && out_ready[gi];
        assign head     = empty ? '0 : mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
        always_ff @(posedge CLK) begin
            if (push) begin
                mem_q[wr_ptr_q] <= IN;
            end
        end

`ifdef DEMUX_COUNT_EN
        logic [15:0] acc_q;

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                acc_q <= '0;
            end else if (push) begin
                acc_q <= acc_q + 16'd1;
            end
        end
`endif
    end

    assign OUT1       = fifo_g[0].head;
    assign OUT1_VALID = !fifo_g[0].empty;
    assign OUT2       = fifo_g[1].head;
    assign OUT2_VALID = !fifo_g[1].empty;

`ifdef DEMUX_COUNT_EN
    assign COUNT1 = fifo_g[0].acc_q;
    assign COUNT2 = fifo_g[1].acc_q;
`endif

endmodule
